// File: rtl/pulse_cmd_sender_if.sv
// pulse_cmd_sender_if: command handshake, result and byte-UART bundle.
// master is the sender's view, slave is the host/UART side.
`timescale 1ns/1ps
interface pulse_cmd_sender_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_ctrl;
    logic [31:0] cmd_data;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_transmitting;
    logic        received;
    logic [7:0]  rx_byte;
    logic        recv_error;
    logic        done;
    logic        ack_ok;
    logic        ack_err;
    logic        ack_timeout;
    logic [7:0]  ack_byte;
    logic [3:0]  attempts;

    modport master (
        input  cmd_valid,
        input  cmd_ctrl,
        input  cmd_data,
        input  is_transmitting,
        input  received,
        input  rx_byte,
        input  recv_error,
        output cmd_ready,
        output transmit,
        output tx_byte,
        output done,
        output ack_ok,
        output ack_err,
        output ack_timeout,
        output ack_byte,
        output attempts
    );

    modport slave (
        output cmd_valid,
        output cmd_ctrl,
        output cmd_data,
        output is_transmitting,
        output received,
        output rx_byte,
        output recv_error,
        input  cmd_ready,
        input  transmit,
        input  tx_byte,
        input  done,
        input  ack_ok,
        input  ack_err,
        input  ack_timeout,
        input  ack_byte,
        input  attempts
    );
endinterface

// File: rtl/pulse_cmd_sender.sv
// pulse_cmd_sender: sends ctrl + 32-bit value as 5 UART bytes, checks the echo.
// Define PULSE_CMD_RETRY_EN to resend failed frames up to MAX_RETRY times.
`timescale 1ns/1ps
module pulse_cmd_sender #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic               clk,
    input  logic               rst,
    pulse_cmd_sender_if.master bus
);

`ifdef PULSE_CMD_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        SEND_START,
        SEND_WAIT,
        RX_WAIT,
        DONE
    } state_t;

    state_t      state_q, state_nx;
    logic [7:0]  ctrl_q, ctrl_nx;
    logic [31:0] data_q, data_nx;
    logic [7:0]  chk_q, chk_nx;
    logic [2:0]  idx_q, idx_nx;
    logic [31:0] tmo_q, tmo_nx;
    logic        ok_q, ok_nx;
    logic        err_q, err_nx;
    logic        to_q, to_nx;
    logic [7:0]  abyte_q, abyte_nx;
    logic [3:0]  att_q, att_nx;

    logic        rx_fin;
    logic        rx_fail;
    logic        rx_match;
    logic        tx_fire;
    logic [7:0]  cur_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= 8'h00;
            data_q  <= 32'h0;
            chk_q   <= 8'h00;
            idx_q   <= 3'd0;
            tmo_q   <= 32'h0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            abyte_q <= 8'h00;
            att_q   <= 4'd0;
        end else begin
            state_q <= state_nx;
            ctrl_q  <= ctrl_nx;
            data_q  <= data_nx;
            chk_q   <= chk_nx;
            idx_q   <= idx_nx;
            tmo_q   <= tmo_nx;
            ok_q    <= ok_nx;
            err_q   <= err_nx;
            to_q    <= to_nx;
            abyte_q <= abyte_nx;
            att_q   <= att_nx;
        end
    end

    // Data bytes go out LSB first, control byte last.
    always_comb begin
        cur_byte = ctrl_q;
        unique case (idx_q)
            3'd0:    cur_byte = data_q[7:0];
            3'd1:    cur_byte = data_q[15:8];
            3'd2:    cur_byte = data_q[23:16];
            3'd3:    cur_byte = data_q[31:24];
            default: cur_byte = ctrl_q;
        endcase
    end

    assign rx_match = !bus.recv_error && (bus.rx_byte == chk_q);

    always_comb begin
        state_nx = state_q;
        ctrl_nx  = ctrl_q;
        data_nx  = data_q;
        chk_nx   = chk_q;
        idx_nx   = idx_q;
        tmo_nx   = tmo_q;
        ok_nx    = ok_q;
        err_nx   = err_q;
        to_nx    = to_q;
        abyte_nx = abyte_q;
        att_nx   = att_q;
        rx_fin   = 1'b0;
        rx_fail  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    ctrl_nx  = bus.cmd_ctrl;
                    data_nx  = bus.cmd_data;
                    chk_nx   = bus.cmd_data[7:0]
                             + bus.cmd_data[15:8]
                             + bus.cmd_data[23:16]
                             + bus.cmd_data[31:24];
                    idx_nx   = 3'd0;
                    att_nx   = 4'd1;
                    ok_nx    = 1'b0;
                    err_nx   = 1'b0;
                    to_nx    = 1'b0;
                    abyte_nx = 8'h00;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (!bus.is_transmitting) begin
                    state_nx = SEND_START;
                end
            end
            SEND_START: begin
                state_nx = SEND_WAIT;
            end
            SEND_WAIT: begin
                if (!bus.is_transmitting) begin
                    if (idx_q == 3'd4) begin
                        tmo_nx   = 32'h0;
                        state_nx = RX_WAIT;
                    end else begin
                        idx_nx   = idx_q + 3'd1;
                        state_nx = SEND;
                    end
                end
            end
            RX_WAIT: begin
                tmo_nx = tmo_q + 32'd1;
                // A byte arriving on the timeout cycle takes priority.
                if (bus.received) begin
                    abyte_nx = bus.rx_byte;
                    ok_nx    = rx_match;
                    err_nx   = !rx_match;
                    to_nx    = 1'b0;
                    rx_fin   = 1'b1;
                    rx_fail  = !rx_match;
                end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    abyte_nx = 8'h00;
                    ok_nx    = 1'b0;
                    err_nx   = 1'b1;
                    to_nx    = 1'b1;
                    rx_fin   = 1'b1;
                    rx_fail  = 1'b1;
                end
                if (rx_fin) begin
                    if (RETRY_EN && rx_fail &&
                        ({28'd0, att_q} <= MAX_RETRY)) begin
                        idx_nx   = 3'd0;
                        att_nx   = att_q + 4'd1;
                        state_nx = SEND;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign tx_fire         = (state_q == SEND) && !bus.is_transmitting;
    assign bus.transmit    = tx_fire;
    assign bus.tx_byte     = tx_fire ? cur_byte : 8'h00;
    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.ack_ok      = ok_q;
    assign bus.ack_err     = err_q;
    assign bus.ack_timeout = to_q;
    assign bus.ack_byte    = abyte_q;
    assign bus.attempts    = att_q;

endmodule

// File: tb/tb_pulse_cmd_sender.sv
// tb_pulse_cmd_sender: directed bench with a byte-UART model and scoreboards
// for transmitted bytes and command results.
`timescale 1ns/1ps
module tb_pulse_cmd_sender;
    localparam int unsigned TMO = 100;
    localparam int BUSY     = 4;
    localparam int ECHO_DLY = 3;
`ifdef PULSE_CMD_RETRY_EN
    localparam int FAIL_FRAMES = 3;
`else
    localparam int FAIL_FRAMES = 1;
`endif

    typedef struct {
        bit         send;
        bit         err;
        logic [7:0] val;
    } echo_t;

    typedef struct {
        bit         ok;
        bit         err;
        bit         to;
        logic [7:0] b;
        logic [3:0] att;
    } ack_t;

    logic clk = 1'b0;
    logic rst;

    pulse_cmd_sender_if bus();

    pulse_cmd_sender #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_tx[$];
    echo_t      echo_q[$];
    ack_t       exp_ack[$];

    int busy          = 0;
    bit pending       = 0;
    bit prev_tx       = 0;
    bit stray_en      = 0;
    int frame_bytes   = 0;
    int echo_wait     = 0;
    int tx_total      = 0;
    int done_total    = 0;
    int frame_end_cyc = 0;
    echo_t echo_cur;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART model: busy for BUSY cycles per byte, echoes after each frame.
    initial begin : uart_model
        bit         tx_s;
        logic [7:0] b_s;
        bus.is_transmitting = 1'b0;
        bus.received        = 1'b0;
        bus.rx_byte         = 8'h00;
        bus.recv_error      = 1'b0;
        forever begin
            @(negedge clk);
            tx_s = bus.transmit;
            b_s  = bus.tx_byte;
            if (bus.done) done_total++;
            if (tx_s) begin
                tx_total++;
                frame_bytes++;
                check("tx_while_busy", 32'(bus.is_transmitting), 0);
                check("tx_back_to_back", 32'(prev_tx), 0);
                check("tx_expected", 32'(exp_tx.size() != 0), 1);
                if (exp_tx.size() != 0)
                    check("tx_byte", 32'(b_s), 32'(exp_tx.pop_front()));
            end
            prev_tx = tx_s;
            bus.received   = 1'b0;
            bus.recv_error = 1'b0;
            if (echo_wait > 0) begin
                echo_wait--;
                if (echo_wait == 0) begin
                    bus.received   = 1'b1;
                    bus.rx_byte    = echo_cur.val;
                    bus.recv_error = echo_cur.err;
                end
            end
            if (busy > 0) begin
                busy--;
                if (busy == 0 && frame_bytes == 5) begin
                    frame_bytes   = 0;
                    frame_end_cyc = cyc;
                    if (echo_q.size() != 0) begin
                        echo_cur = echo_q.pop_front();
                        if (echo_cur.send) echo_wait = ECHO_DLY;
                    end
                end
                if (stray_en && frame_bytes == 2 && busy == 2) begin
                    bus.received = 1'b1;
                    bus.rx_byte  = 8'hAA;
                    stray_en     = 1'b0;
                end
            end
            if (pending) begin
                busy    = BUSY;
                pending = 1'b0;
            end
            bus.is_transmitting = (busy > 0);
            if (tx_s) pending = 1'b1;
        end
    end

    task automatic push_frame(input logic [7:0] c, input logic [31:0] d);
        exp_tx.push_back(d[7:0]);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[23:16]);
        exp_tx.push_back(d[31:24]);
        exp_tx.push_back(c);
    endtask

    task automatic push_echo(input bit s, input bit e, input logic [7:0] v);
        echo_t x;
        x.send = s;
        x.err  = e;
        x.val  = v;
        echo_q.push_back(x);
    endtask

    task automatic push_ack(input bit ok, input bit err, input bit to,
                            input logic [7:0] b, input logic [3:0] att);
        ack_t a;
        a.ok  = ok;
        a.err = err;
        a.to  = to;
        a.b   = b;
        a.att = att;
        exp_ack.push_back(a);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy == 0 && !pending && echo_wait == 0 &&
                !bus.is_transmitting) break;
        end
    endtask

    task automatic issue(input logic [7:0] c, input logic [31:0] d,
                         input bit hold);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ctrl  = c;
        bus.cmd_data  = d;
        @(negedge clk);
        check("first_strobe", 32'(bus.transmit), 1);
        check("ack_cleared",
              32'({bus.ack_byte, bus.ack_ok, bus.ack_err, bus.ack_timeout}), 0);
        check("attempts_start", 32'(bus.attempts), 1);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        int   rdy_bad;
        bit   seen;
        ack_t e;
        rdy_bad = 0;
        seen    = 1'b0;
        dcyc    = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
            if (bus.cmd_ready) rdy_bad++;
        end
        bus.cmd_valid = 1'b0;
        check("ready_low", rdy_bad, 0);
        check("done_seen", 32'(seen), 1);
        if (seen && exp_ack.size() != 0) begin
            e = exp_ack.pop_front();
            check("ack_flags",
                  32'({bus.ack_ok, bus.ack_err, bus.ack_timeout}),
                  32'({e.ok, e.err, e.to}));
            check("ack_byte", 32'(bus.ack_byte), 32'(e.b));
            check("attempts", 32'(bus.attempts), 32'(e.att));
            @(negedge clk);
            check("done_pulse", 32'(bus.done), 0);
            check("ack_hold", 32'({bus.ack_byte, bus.attempts}),
                  32'({e.b, e.att}));
        end
    endtask

    task automatic end_test(input int d0, input int t0, input int nbytes);
        repeat (12) @(negedge clk);
        check("frame_len", tx_total - t0, nbytes);
        check("tx_left", exp_tx.size(), 0);
        check("done_count", done_total - d0, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int dc;
        int d0;
        int t0;
        bit hit;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_ctrl  = 8'h00;
        bus.cmd_data  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        check("rst_tx", 32'({bus.transmit, bus.tx_byte}), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_acks",
              32'({bus.ack_byte, bus.ack_ok, bus.ack_err, bus.ack_timeout}), 0);
        check("rst_attempts", 32'(bus.attempts), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.cmd_ready), 1);

        // Period command with a matching echo.
        d0 = done_total;
        t0 = tx_total;
        push_frame(8'h01, 32'h0000_07D0);
        push_echo(1'b1, 1'b0, 8'hD7);
        push_ack(1'b1, 1'b0, 1'b0, 8'hD7, 4'd1);
        issue(8'h01, 32'h0000_07D0, 1'b0);
        wait_done(dc);
        check("echo_latency", dc - frame_end_cyc, ECHO_DLY + 1);
        end_test(d0, t0, 5);

        // Wrong echo (expected checksum 0x1E).
        wait_idle();
        d0 = done_total;
        t0 = tx_total;
        for (int i = 0; i < FAIL_FRAMES; i++) begin
            push_frame(8'h02, 32'h0000_001E);
            push_echo(1'b1, 1'b0, 8'h00);
        end
        push_ack(1'b0, 1'b1, 1'b0, 8'h00, 4'(FAIL_FRAMES));
        issue(8'h02, 32'h0000_001E, 1'b0);
        wait_done(dc);
        end_test(d0, t0, 5 * FAIL_FRAMES);

        // No echo at all.
        wait_idle();
        d0 = done_total;
        t0 = tx_total;
        for (int i = 0; i < FAIL_FRAMES; i++)
            push_frame(8'h04, 32'h0000_0100);
        push_ack(1'b0, 1'b1, 1'b1, 8'h00, 4'(FAIL_FRAMES));
        issue(8'h04, 32'h0000_0100, 1'b0);
        wait_done(dc);
        check("timeout_latency", dc - frame_end_cyc, TMO + 1);
        end_test(d0, t0, 5 * FAIL_FRAMES);

        // Framing error on a byte that would otherwise match (chk 0x2E).
        wait_idle();
        d0 = done_total;
        t0 = tx_total;
        for (int i = 0; i < FAIL_FRAMES; i++) begin
            push_frame(8'h07, 32'h0A0B_0C0D);
            push_echo(1'b1, 1'b1, 8'h2E);
        end
        push_ack(1'b0, 1'b1, 1'b0, 8'h2E, 4'(FAIL_FRAMES));
        issue(8'h07, 32'h0A0B_0C0D, 1'b0);
        wait_done(dc);
        end_test(d0, t0, 5 * FAIL_FRAMES);

        // Stray byte during SEND_WAIT, cmd_valid held high (chk 0x14).
        wait_idle();
        d0 = done_total;
        t0 = tx_total;
        stray_en = 1'b1;
        push_frame(8'h05, 32'h1234_5678);
        push_echo(1'b1, 1'b0, 8'h14);
        push_ack(1'b1, 1'b0, 1'b0, 8'h14, 4'd1);
        issue(8'h05, 32'h1234_5678, 1'b1);
        wait_done(dc);
        end_test(d0, t0, 5);

        // Reset after the second byte strobe.
        wait_idle();
        push_frame(8'h08, 32'h0000_0064);
        issue(8'h08, 32'h0000_0064, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_bytes >= 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("second_strobe_seen", 32'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(bus.cmd_ready), 1);
        check("midrst_tx", 32'({bus.transmit, bus.tx_byte}), 0);
        check("midrst_acks",
              32'({bus.ack_byte, bus.ack_ok, bus.ack_err, bus.ack_timeout}), 0);
        check("midrst_attempts", 32'(bus.attempts), 0);
        rst = 1'b0;
        exp_tx.delete();
        frame_bytes = 0;
        wait_idle();
        d0 = done_total;
        t0 = tx_total;
        push_frame(8'h03, 32'h0000_00FF);
        push_echo(1'b1, 1'b0, 8'hFF);
        push_ack(1'b1, 1'b0, 1'b0, 8'hFF, 4'd1);
        issue(8'h03, 32'h0000_00FF, 1'b0);
        wait_done(dc);
        end_test(d0, t0, 5);

`ifdef PULSE_CMD_RETRY_EN
        // First echo wrong, second correct (chk 0x03).
        wait_idle();
        d0 = done_total;
        t0 = tx_total;
        push_frame(8'h06, 32'h0000_0003);
        push_frame(8'h06, 32'h0000_0003);
        push_echo(1'b1, 1'b0, 8'h55);
        push_echo(1'b1, 1'b0, 8'h03);
        push_ack(1'b1, 1'b0, 1'b0, 8'h03, 4'd2);
        issue(8'h06, 32'h0000_0003, 1'b0);
        wait_done(dc);
        end_test(d0, t0, 10);

        // Three wrong echoes.
        wait_idle();
        d0 = done_total;
        t0 = tx_total;
        for (int i = 0; i < 3; i++) begin
            push_frame(8'h06, 32'h0000_0003);
            push_echo(1'b1, 1'b0, 8'h66);
        end
        push_ack(1'b0, 1'b1, 1'b0, 8'h66, 4'd3);
        issue(8'h06, 32'h0000_0003, 1'b0);
        wait_done(dc);
        end_test(d0, t0, 15);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
